// File: rtl/seq_alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for seq_alu.
package seq_alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_INV = 4'd5;
    localparam logic [OP_W-1:0] OP_CLR = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL = 4'd7;
    localparam logic [OP_W-1:0] OP_SHR = 4'd8;
    localparam logic [OP_W-1:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ops that run on the multi-cycle shift/multiply datapath.
    function automatic logic is_seq_op(input logic [OP_W-1:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU ops (ADD..CLR) with carry/overflow; anything else yields zero.
module alu_comb_core
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_c,
    output logic             carry_c,
    output logic             overflow_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Result and flag selection; reserved and multi-cycle opcodes fall to CLR.
    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} - {1'b0, b};
        res_c      = '0;
        carry_c    = 1'b0;
        overflow_c = 1'b0;
        case (op)
            OP_ADD: begin
                res_c      = sum[WIDTH-1:0];
                carry_c    = sum[WIDTH];
                overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c      = diff[WIDTH-1:0];
                carry_c    = diff[WIDTH];
                overflow_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_INV:  res_c = ~a;
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic ops plus bit-serial shifts and shift-add multiply.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic [OP_W-1:0]    op_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   amt;
    logic [WIDTH-1:0]   sreg;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   core_res;
    logic               core_carry;
    logic               core_ovf;

    logic [WIDTH-1:0]   shl_nxt;
    logic [WIDTH-1:0]   shr_nxt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_nxt;

    logic               load;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_carry;
    logic               fin_ovf;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op         (op),
        .a          (a),
        .b          (b),
        .res_c      (core_res),
        .carry_c    (core_carry),
        .overflow_c (core_ovf)
    );

    assign accept = in_valid && (state == ST_IDLE);

    // Shift amount saturates at WIDTH; beyond that every bit is already gone.
    always_comb begin
        amt = (b > WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(b);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_seq_op(op)) begin
                        state_nxt = ST_DONE;
                    end else if ((op != OP_MUL) && (amt == '0)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // One step of the shift / shift-add multiply datapath.
    always_comb begin
        shl_nxt = {sreg[WIDTH-2:0], 1'b0};
        shr_nxt = {1'b0, sreg[WIDTH-1:1]};
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, sreg} : '0);
        acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end

    // Select the value and flags committed when entering DONE.
    always_comb begin
        load      = 1'b0;
        fin_res   = core_res;
        fin_carry = core_carry;
        fin_ovf   = core_ovf;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_seq_op(op)) begin
                        load = 1'b1;
                    end else if ((op != OP_MUL) && (amt == '0)) begin
                        load      = 1'b1;
                        fin_res   = a;
                        fin_carry = 1'b0;
                        fin_ovf   = 1'b0;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt == CNT_W'(1)) begin
                    load = 1'b1;
                    case (op_q)
                        OP_SHL: begin
                            fin_res   = shl_nxt;
                            fin_carry = sreg[WIDTH-1];
                            fin_ovf   = 1'b0;
                        end
                        OP_SHR: begin
                            fin_res   = shr_nxt;
                            fin_carry = sreg[0];
                            fin_ovf   = 1'b0;
                        end
                        default: begin
                            fin_res   = acc_nxt[WIDTH-1:0];
                            fin_carry = |acc_nxt[2*WIDTH-1:WIDTH];
                            fin_ovf   = |acc_nxt[2*WIDTH-1:WIDTH];
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Operand capture at acceptance, then one shift/add step per EXEC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= OP_CLR;
            cnt  <= '0;
            sreg <= '0;
            acc  <= '0;
        end else if (accept) begin
            op_q <= op;
            cnt  <= (op == OP_MUL) ? CNT_W'(WIDTH) : amt;
            sreg <= a;
            acc  <= {{WIDTH{1'b0}}, b};
        end else if (state == ST_EXEC) begin
            cnt <= cnt - CNT_W'(1);
            if (op_q == OP_SHL) begin
                sreg <= shl_nxt;
            end else if (op_q == OP_SHR) begin
                sreg <= shr_nxt;
            end else begin
                acc <= acc_nxt;
            end
        end
    end

    // Result/flag registers, held untouched through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (load) begin
            result   <= fin_res;
            carry    <= fin_carry;
            overflow <= fin_ovf;
            zero     <= (fin_res == '0);
            negative <= fin_res[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4): directed vectors plus a per-cycle reference model.
module tb_seq_alu;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        logic [7:0]   lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    int total = 0;
    int bad   = 0;

    // model state: at most one request in flight
    bit   m_busy   = 1'b0;
    int   m_remain = 0;
    exp_t m_exp;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected outcome of one request, from plain integer arithmetic.
    function automatic exp_t model_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint ua, ub, m, half, sa, sb, s, ss, p, r;
        int n;
        exp_t e;
        ua   = longint'(av);
        ub   = longint'(bv);
        m    = (longint'(1) << W) - 1;
        half = longint'(1) << (W - 1);
        sa   = (ua >= half) ? ua - (longint'(1) << W) : ua;
        sb   = (ub >= half) ? ub - (longint'(1) << W) : ub;
        n    = (ub > W) ? W : int'(ub);
        e    = '0;
        e.lat = 8'd1;
        r    = 0;
        case (o)
            4'd0: begin
                s = ua + ub; r = s & m; e.c = (s > m);
                ss = sa + sb; e.v = (ss >= half) || (ss < -half);
            end
            4'd1: begin
                r = (ua - ub) & m; e.c = (ua < ub);
                ss = sa - sb; e.v = (ss >= half) || (ss < -half);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = (~ua) & m;
            4'd7: begin
                r = (ua << n) & m;
                e.c = (n == 0) ? 1'b0 : 1'(((ua >> (W - n)) & 1));
                e.lat = 8'(n + 1);
            end
            4'd8: begin
                r = ua >> n;
                e.c = (n == 0) ? 1'b0 : 1'(((ua >> (n - 1)) & 1));
                e.lat = 8'(n + 1);
            end
            4'd9: begin
                p = ua * ub; r = p & m;
                e.c = ((p >> W) != 0); e.v = e.c;
                e.lat = 8'(W + 1);
            end
            default: r = 0;
        endcase
        e.r = W'(r);
        e.z = (r == 0);
        e.n = 1'(((r >> (W - 1)) & 1));
        return e;
    endfunction

    // Model bookkeeping: accept when idle, count down latency, retire on handshake.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_remain <= 0;
        end else if (m_busy) begin
            if (m_remain == 0) begin
                if (out_ready) m_busy <= 1'b0;
            end else begin
                m_remain <= m_remain - 1;
            end
        end else if (in_valid) begin
            m_exp    <= model_op(op, a, b);
            m_remain <= int'(model_op(op, a, b).lat) - 1;
            m_busy   <= 1'b1;
        end
    end

    // Per-cycle comparison of the handshake and, when valid, result and flags.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", out_valid, (m_busy && m_remain == 0));
            chk("in_ready", in_ready, !m_busy);
            if (m_busy && m_remain == 0)
                chk("result_flags", {result, carry, overflow, zero, negative},
                    {m_exp.r, m_exp.c, m_exp.v, m_exp.z, m_exp.n});
        end
    end

    // Wait (bounded) for out_valid after an accept edge and check literal expectations.
    task automatic wait_out(input string nm, input int er, input int ec, input int ev, input int el, input bit xfer);
        int cyc;
        bit got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (out_valid) got = 1'b1;
        end
        if (!got) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_latency"}, cyc, el);
            chk({nm, "_result"}, result, er);
            chk({nm, "_carry"}, carry, ec);
            chk({nm, "_overflow"}, overflow, ev);
        end
        if (xfer) @(posedge clk);
    endtask

    // Issue one request, scramble operands after acceptance, check the outcome.
    task automatic drive(input string nm, input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int er, input int ec, input int ev, input int el);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        op = o;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        a  = W'($urandom);
        b  = W'($urandom);
        wait_out(nm, er, ec, ev, el, 1'b1);
    endtask

    exp_t pin;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'd0;
        a         = '0;
        b         = '0;

        // model pinned against hand-computed values
        pin = model_op(4'd0, 4'd7, 4'd1);
        chk("pin_add", {pin.r, pin.c, pin.v, pin.z, pin.n}, {4'd8, 1'b0, 1'b1, 1'b0, 1'b1});
        pin = model_op(4'd1, 4'd3, 4'd5);
        chk("pin_sub", {pin.r, pin.c, pin.v, pin.n}, {4'd14, 1'b1, 1'b0, 1'b1});
        pin = model_op(4'd7, 4'b1011, 4'd2);
        chk("pin_shl", {pin.r, pin.c, pin.lat}, {4'b1100, 1'b0, 8'd3});
        pin = model_op(4'd8, 4'b1011, 4'd9);
        chk("pin_shr", {pin.r, pin.lat}, {4'd0, 8'd5});
        pin = model_op(4'd9, 4'd6, 4'd6);
        chk("pin_mul", {pin.r, pin.c, pin.v, pin.lat}, {4'd4, 1'b1, 1'b1, 8'd5});

        // reset state
        #1;
        chk("rst_result", result, 0);
        chk("rst_flags", {carry, overflow, zero, negative}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        //    name        op     a        b        res  c  v  lat
        drive("add7_1",  4'd0,  4'd7,    4'd1,    8,   0, 1, 1);
        drive("sub3_5",  4'd1,  4'd3,    4'd5,    14,  1, 0, 1);
        drive("add15_1", 4'd0,  4'd15,   4'd1,    0,   1, 0, 1);
        drive("sub8_1",  4'd1,  4'd8,    4'd1,    7,   0, 1, 1);
        drive("and",     4'd2,  4'd12,   4'd10,   8,   0, 0, 1);
        drive("or",      4'd3,  4'd12,   4'd3,    15,  0, 0, 1);
        drive("xor",     4'd4,  4'd15,   4'd15,   0,   0, 0, 1);
        drive("inv",     4'd5,  4'd5,    4'd0,    10,  0, 0, 1);
        drive("clr",     4'd6,  4'd9,    4'd9,    0,   0, 0, 1);
        drive("resv12",  4'd12, 4'd7,    4'd3,    0,   0, 0, 1);
        drive("shl2",    4'd7,  4'b1011, 4'd2,    12,  0, 0, 3);
        drive("shr9",    4'd8,  4'b1011, 4'd9,    0,   1, 0, 5);
        drive("shl0",    4'd7,  4'b1011, 4'd0,    11,  0, 0, 1);
        drive("shr1",    4'd8,  4'b1011, 4'd1,    5,   1, 0, 2);
        drive("shl4",    4'd7,  4'd3,    4'd4,    0,   1, 0, 5);
        drive("mul5_3",  4'd9,  4'd5,    4'd3,    15,  0, 0, 5);
        drive("mul6_6",  4'd9,  4'd6,    4'd6,    4,   1, 1, 5);
        drive("mul15_15",4'd9,  4'd15,   4'd15,   1,   1, 1, 5);

        // back-pressure: DONE held three cycles with a competing request pending
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 4'd0; a = 4'd2; b = 4'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out("hold_add", 5, 0, 0, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op = 4'd9; a = 4'd3; b = 4'd3;
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", {result, carry, overflow, zero, negative}, {4'd5, 4'b0000});
            @(negedge clk);
        end
        chk("hold_end_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out("after_hold_mul", 9, 0, 0, 5, 1'b1);

        // reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd9; a = 4'd7; b = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_flags", {carry, overflow, zero, negative}, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("postrst_no_valid", out_valid, 0);
        end
        chk("postrst_in_ready", in_ready, 1);

        drive("recover_add", 4'd0, 4'd1, 4'd2, 3, 0, 0, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
